ssp_rx_fifo: RTL and testbench
==============================

Name: ssp_rx_fifo

Overview:
Receive-side FIFO of the SSP block. It buffers 8-bit words deserialised by the SSP receive logic (RxData plus a one-cycle write strobe) and hands them to the processor through the APB-style read path (PSEL, PWRITE=0, PRDATA). SSPRXINTR is raised to the processor while the FIFO is full, so the processor drains it before data is lost. It mirrors the transmit FIFO: the processor is the consumer and the SSP logic is the producer.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 4, number of word entries; must be a power of 2
ADDR_W, 2, pointer width; equals log2(DEPTH)

Ports:
PCLK  input  1  system clock; all state updates on the rising edge
CLEAR_B  input  1  reset, synchronous, active-low
PSEL  input  1  processor select for the receive FIFO
PWRITE  input  1  processor direction; 0 = read (pop)
PRDATA  output  WIDTH  head-of-FIFO word presented to the processor
RxData  input  WIDTH  word assembled by the SSP receive logic
RxWordValid  input  1  one-cycle strobe: push RxData this edge
SSPRXINTR  output  1  high while the FIFO holds DEPTH words (full)
RxOverrun  output  1  sticky flag: a push was dropped because the FIFO was full

Behaviour:
- Reset: on a PCLK edge with CLEAR_B=0, clear rd_ptr, wr_ptr and count; RxOverrun=0. Reset dominates any simultaneous push or pop.
- After reset: PRDATA=0, SSPRXINTR=0, RxOverrun=0. Memory contents are don't-care.
- State:
  - rd_ptr and wr_ptr are ADDR_W bits and wrap modulo DEPTH (3 -> 0).
  - count is ADDR_W+1 bits, range 0..DEPTH.
  - empty = (count==0); full = (count==DEPTH).
- Push:
  - Condition: RxWordValid=1 and (not full, or a pop in the same cycle).
  - Action: mem[wr_ptr] <= RxData; wr_ptr increments.
- Pop:
  - Condition: PSEL=1, PWRITE=0 and not empty.
  - Action: rd_ptr increments.
  - One pop per PCLK cycle while the read condition holds; the processor asserts PSEL for exactly one cycle per word.
- PRDATA:
  - Combinational: mem[rd_ptr] when not empty, 0 when empty.
  - The word to be popped is visible during the pop cycle (zero-latency read data).
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged, and both pointers advance.
- Full plus push with no pop: word dropped, pointers unchanged. RxOverrun <= 1 and stays 1 until CLEAR_B.
- Full plus push plus pop: both happen, no overrun, FIFO stays full.
- Empty plus pop: ignored, no pointer change, PRDATA=0.
- Empty plus pop plus push: push happens, pop is ignored (no fall-through). The new word appears on PRDATA the next cycle.
- PSEL=1 with PWRITE=1: no effect on this block. That is a transmit-side access.
- SSPRXINTR is combinational from count (count==DEPTH). It rises the cycle after the DEPTH-th push and falls the cycle after the first pop from full.
- Push latency: a word pushed at edge N is readable on PRDATA after edge N if it is the head.

Decomposition:
- Shared package ssp_pkg holds:
  - SSP_WORD_W = 8
  - SSP_FIFO_DEPTH = 4
  - SSP_FIFO_AW = 2
- The transmit FIFO and this block both use these constants.
- One natural sub-module, ssp_fifo_ram:
  - DEPTH x WIDTH register array.
  - Synchronous write port (we, waddr, wdata); asynchronous read port (raddr, rdata).
  - Shared with the transmit FIFO.
- Pointer, count and flag logic stays in ssp_rx_fifo.

Test Plan:
- Reset: CLEAR_B=0 for 2 cycles with RxWordValid=1 and RxData=8'hAA -> PRDATA=0, SSPRXINTR=0, RxOverrun=0, FIFO still empty after release.
- Fill and drain: push 8'h11, 22, 33, 44 on consecutive cycles -> SSPRXINTR=1 after the 4th edge. Then 4 single-cycle reads return 11, 22, 33, 44 in order, SSPRXINTR=0 after the first pop, and PRDATA=0 when empty.
- Overrun: fill with 01..04, then push 8'h55 with no read -> RxOverrun=1 (sticky), 55 discarded, reads return 01..04. RxOverrun clears only on CLEAR_B=0.
- Simultaneous at full: full with A0..A3, push 8'hB0 in the same cycle as a read -> read yields A0, SSPRXINTR stays 1, no overrun, subsequent reads give A1, A2, A3, B0.
- Empty corner: push 8'h5A and read in the same cycle on an empty FIFO -> no pop, PRDATA=5A on the next cycle, count=1. A read with PWRITE=1 does not pop.
- Wrap-around: 10 interleaved push/pop cycles with values 00..09 -> pointers wrap past 3 and every word is read back in order with no loss.

Source files
------------

// File: rtl/ssp_pkg.sv
// Shared SSP constants and types used by the receive and transmit FIFOs.
package ssp_pkg;

  localparam int unsigned SSP_WORD_W     = 8;
  localparam int unsigned SSP_FIFO_DEPTH = 4;
  localparam int unsigned SSP_FIFO_AW    = 2;

  typedef logic [SSP_WORD_W-1:0]  ssp_word_t;
  typedef logic [SSP_FIFO_AW-1:0] ssp_fifo_ptr_t;

endpackage

// File: rtl/ssp_fifo_ram.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
module ssp_fifo_ram
  import ssp_pkg::*;
#(
  parameter int unsigned WIDTH  = SSP_WORD_W,
  parameter int unsigned DEPTH  = SSP_FIFO_DEPTH,
  parameter int unsigned ADDR_W = SSP_FIFO_AW
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store the incoming word at the write address.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ssp_rx_fifo.sv
// SSP receive FIFO: SSP logic pushes words, processor pops them via the read path.
module ssp_rx_fifo
  import ssp_pkg::*;
#(
  parameter int unsigned WIDTH  = SSP_WORD_W,
  parameter int unsigned DEPTH  = SSP_FIFO_DEPTH,
  parameter int unsigned ADDR_W = SSP_FIFO_AW
) (
  input  logic             PCLK,
  input  logic             CLEAR_B,
  input  logic             PSEL,
  input  logic             PWRITE,
  output logic [WIDTH-1:0] PRDATA,
  input  logic [WIDTH-1:0] RxData,
  input  logic             RxWordValid,
  output logic             SSPRXINTR,
  output logic             RxOverrun
);

  localparam logic [ADDR_W:0] LP_FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overrun;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_ram_we;
  logic [WIDTH-1:0]  w_rdata;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == LP_FULL_COUNT);
  // A pop frees a slot in the same cycle, so a push at full is accepted then.
  assign w_pop    = PSEL && !PWRITE && !w_empty;
  assign w_push   = RxWordValid && (!w_full || w_pop);
  assign w_ram_we = w_push && CLEAR_B;

  ssp_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (PCLK),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (RxData),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Advance pointers, track occupancy and latch the sticky overrun flag.
  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (RxWordValid && !w_push) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign PRDATA    = w_empty ? '0 : w_rdata;
  assign SSPRXINTR = w_full;
  assign RxOverrun = r_overrun;

endmodule

// File: tb/tb_ssp_rx_fifo.sv
// Self-checking bench for ssp_rx_fifo: directed vector table, hand sequences, random vs queue model.
module tb_ssp_rx_fifo;
  import ssp_pkg::*;

  logic       PCLK = 1'b0;
  logic       CLEAR_B;
  logic       PSEL;
  logic       PWRITE;
  logic [7:0] PRDATA;
  logic [7:0] RxData;
  logic       RxWordValid;
  logic       SSPRXINTR;
  logic       RxOverrun;

  always #5 PCLK = ~PCLK;

  ssp_rx_fifo #(
    .WIDTH  (SSP_WORD_W),
    .DEPTH  (SSP_FIFO_DEPTH),
    .ADDR_W (SSP_FIFO_AW)
  ) dut (
    .PCLK        (PCLK),
    .CLEAR_B     (CLEAR_B),
    .PSEL        (PSEL),
    .PWRITE      (PWRITE),
    .PRDATA      (PRDATA),
    .RxData      (RxData),
    .RxWordValid (RxWordValid),
    .SSPRXINTR   (SSPRXINTR),
    .RxOverrun   (RxOverrun)
  );

  typedef struct {
    logic       cb;
    logic       psel;
    logic       pwrite;
    logic       valid;
    logic [7:0] data;
    logic [7:0] exp_prdata;
    logic       exp_intr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: occupancy is the queue size, head is q[0].
  logic [7:0] mq[$];
  logic       movr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] ep, input logic ei, input logic eo);
    check({tag, ".PRDATA"},    {24'h0, PRDATA},    {24'h0, ep});
    check({tag, ".SSPRXINTR"}, {31'h0, SSPRXINTR}, {31'h0, ei});
    check({tag, ".RxOverrun"}, {31'h0, RxOverrun}, {31'h0, eo});
  endtask

  task automatic drive(input logic cb, input logic ps, input logic pw, input logic v, input logic [7:0] d);
    CLEAR_B     = cb;
    PSEL        = ps;
    PWRITE      = pw;
    RxWordValid = v;
    RxData      = d;
  endtask

  task automatic cycle(input logic cb, input logic ps, input logic pw, input logic v, input logic [7:0] d);
    drive(cb, ps, pw, v, d);
    @(posedge PCLK);
    #1;
  endtask

  task automatic model_step(input logic cb, input logic ps, input logic pw, input logic v, input logic [7:0] d);
    bit was_full;
    bit pop;
    if (!cb) begin
      mq.delete();
      movr = 1'b0;
    end else begin
      was_full = (mq.size() == 4);
      pop      = ps && !pw && (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      if (v) begin
        if (!was_full || pop) mq.push_back(d);
        else movr = 1'b1;
      end
    end
  endtask

  function automatic void add(input logic cb, input logic ps, input logic pw, input logic v,
                              input logic [7:0] d, input logic [7:0] ep, input logic ei, input logic eo);
    vec_t t;
    t.cb = cb; t.psel = ps; t.pwrite = pw; t.valid = v; t.data = d;
    t.exp_prdata = ep; t.exp_intr = ei; t.exp_ovr = eo;
    vecs.push_back(t);
  endfunction

  initial begin
    logic [7:0] rd;
    logic [7:0] wv;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // ---- directed table: expected values after each edge ----
    // reset with push asserted
    add(0,0,0,1,8'hAA, 8'h00,0,0);
    add(0,0,0,1,8'hAA, 8'h00,0,0);
    add(1,0,0,0,8'h00, 8'h00,0,0);
    // fill and drain
    add(1,0,0,1,8'h11, 8'h11,0,0);
    add(1,0,0,1,8'h22, 8'h11,0,0);
    add(1,0,0,1,8'h33, 8'h11,0,0);
    add(1,0,0,1,8'h44, 8'h11,1,0);
    add(1,1,0,0,8'h00, 8'h22,0,0);
    add(1,1,0,0,8'h00, 8'h33,0,0);
    add(1,1,0,0,8'h00, 8'h44,0,0);
    add(1,1,0,0,8'h00, 8'h00,0,0);
    add(1,1,0,0,8'h00, 8'h00,0,0);   // pop on empty ignored
    // overrun
    add(1,0,0,1,8'h01, 8'h01,0,0);
    add(1,0,0,1,8'h02, 8'h01,0,0);
    add(1,0,0,1,8'h03, 8'h01,0,0);
    add(1,0,0,1,8'h04, 8'h01,1,0);
    add(1,0,0,1,8'h55, 8'h01,1,1);
    add(1,1,0,0,8'h00, 8'h02,0,1);
    add(1,1,0,0,8'h00, 8'h03,0,1);
    add(1,1,0,0,8'h00, 8'h04,0,1);
    add(1,1,0,0,8'h00, 8'h00,0,1);
    add(1,0,0,0,8'h00, 8'h00,0,1);
    add(0,0,0,0,8'h00, 8'h00,0,0);
    // simultaneous push and pop at full
    add(1,0,0,1,8'hA0, 8'hA0,0,0);
    add(1,0,0,1,8'hA1, 8'hA0,0,0);
    add(1,0,0,1,8'hA2, 8'hA0,0,0);
    add(1,0,0,1,8'hA3, 8'hA0,1,0);
    add(1,1,0,1,8'hB0, 8'hA1,1,0);
    add(1,1,0,0,8'h00, 8'hA2,0,0);
    add(1,1,0,0,8'h00, 8'hA3,0,0);
    add(1,1,0,0,8'h00, 8'hB0,0,0);
    add(1,1,0,0,8'h00, 8'h00,0,0);
    // empty corner: push+read on empty, then a write-direction access
    add(1,1,0,1,8'h5A, 8'h5A,0,0);
    add(1,1,1,0,8'h00, 8'h5A,0,0);
    add(1,1,0,0,8'h00, 8'h00,0,0);
    // wrap-around: interleaved push/pop of 00..09
    add(1,0,0,1,8'h00, 8'h00,0,0);
    for (int unsigned k = 1; k < 10; k++) add(1,1,0,1,8'(k), 8'(k),0,0);
    add(1,1,0,0,8'h00, 8'h00,0,0);

    foreach (vecs[i]) begin
      cycle(vecs[i].cb, vecs[i].psel, vecs[i].pwrite, vecs[i].valid, vecs[i].data);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_prdata, vecs[i].exp_intr, vecs[i].exp_ovr);
    end

    // ---- hand sequence: head word visible during the pop cycle ----
    cycle(0,0,0,0,8'h00);
    cycle(1,0,0,1,8'hC1);
    cycle(1,0,0,1,8'hC2);
    cycle(1,0,0,1,8'hC3);
    drive(1,1,0,0,8'h00);
    #1;
    check("zl_before_edge.PRDATA", {24'h0, PRDATA}, 32'hC1);
    @(posedge PCLK);
    #1;
    check("zl_after_edge.PRDATA", {24'h0, PRDATA}, 32'hC2);

    // ---- hand sequence: overrun stays set across idle and pops, reset beats push+pop ----
    cycle(1,0,0,1,8'hC4);
    cycle(1,0,0,1,8'hC5);
    cycle(1,0,0,1,8'hEE);
    for (int unsigned k = 0; k < 6; k++) begin
      cycle(1,0,0,0,8'h00);
      check("sticky.RxOverrun", {31'h0, RxOverrun}, 32'h1);
    end
    check("sticky.SSPRXINTR", {31'h0, SSPRXINTR}, 32'h1);
    cycle(0,1,0,1,8'h77);
    check_outs("reset_dom", 8'h00, 1'b0, 1'b0);
    cycle(1,0,0,0,8'h00);
    check_outs("reset_dom_after", 8'h00, 1'b0, 1'b0);

    // ---- randomized traffic against the queue model ----
    model_step(0,0,0,0,8'h00);
    cycle(0,0,0,0,8'h00);
    for (int unsigned n = 0; n < 400; n++) begin
      logic cb, ps, pw, v;
      cb = ($urandom_range(0, 59) != 0);
      ps = ($urandom_range(0, 99) < 45);
      pw = ($urandom_range(0, 9) == 0);
      v  = ($urandom_range(0, 99) < 55);
      wv = 8'($urandom);
      model_step(cb, ps, pw, v, wv);
      cycle(cb, ps, pw, v, wv);
      rd = (mq.size() > 0) ? mq[0] : 8'h00;
      check_outs($sformatf("rnd%0d", n), rd, (mq.size() == 4), movr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
